// File: rtl/fifo_stream_reader_pkg.sv
// Shared widths and the modulo pointer-increment helper for the FIFO stream reader.
package fifo_stream_reader_pkg;

  localparam int PTR_W   = 3;  // covers buffer depths up to 8
  localparam int LEVEL_W = 4;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr,
                                                 input int depth);
    return (ptr == PTR_W'(depth - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

endpackage

// File: rtl/fifo_stream_reader_buf.sv
// Small circular buffer with modulo-depth pointers; head word is presented
// combinationally so the stream sees it the cycle after capture.
module fifo_stream_reader_buf
  import fifo_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BUF_DEPTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [LEVEL_W-1:0]    level
);

  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_next(wr_ptr, BUF_DEPTH);
      end
      if (pop) rd_ptr <= ptr_next(rd_ptr, BUF_DEPTH);
      // Simultaneous push and pop leaves the occupancy unchanged.
      if (push && !pop)      level <= level + LEVEL_W'(1);
      else if (!push && pop) level <= level - LEVEL_W'(1);
    end
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a 1-cycle-latency FIFO read port into a bubble-free valid/ready stream.
// Reads are issued on credit (buffered + in-flight words) and never look at m_ready.
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BUF_DEPTH  = 3,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  xfer_count,
  output logic [LEVEL_W-1:0]    buf_level
);

  logic             inflight;
  logic             pop;
  logic [LEVEL_W:0] credit_used;

  // Handshake: a word moves downstream on a rising edge where m_valid && m_ready;
  // m_valid only falls after such a transfer and m_data holds while stalled.
  assign credit_used = {1'b0, buf_level} + {{LEVEL_W{1'b0}}, inflight};
  assign fifo_rd_en  = !rst && !fifo_empty && (credit_used < (LEVEL_W+1)'(BUF_DEPTH));
  assign m_valid     = (buf_level != '0);
  assign pop         = m_valid && m_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight   <= 1'b0;
      xfer_count <= '0;
    end else begin
      inflight <= fifo_rd_en;
      if (pop) xfer_count <= xfer_count + CNT_WIDTH'(1);
    end
  end

  fifo_stream_reader_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .BUF_DEPTH  (BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data (fifo_dout),
    .pop       (pop),
    .head_data (m_data),
    .level     (buf_level)
  );

  // The credit rule must keep buffered plus in-flight words within the buffer.
  always @(posedge clk) begin
    if (!rst) assert (credit_used <= (LEVEL_W+1)'(BUF_DEPTH));
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Stream reader bench: behavioural 1-cycle-latency FIFOs feed a depth-3 and a
// depth-2/4-bit-counter instance; a queue holds the words expected downstream.
module tb_fifo_stream_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       fifo_empty1, fifo_rd_en1, m_valid1, m_ready1;
  logic [7:0] fifo_dout1, m_data1;
  logic [15:0] xfer1;
  logic [3:0] level1;

  logic       fifo_empty2, fifo_rd_en2, m_valid2, m_ready2;
  logic [7:0] fifo_dout2, m_data2;
  logic [3:0] xfer2;
  logic [3:0] level2;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp2_q[$];

  // Clock and reset values
  always #5 clk = ~clk;

  fifo_stream_reader #(.DATA_WIDTH(8), .BUF_DEPTH(3), .CNT_WIDTH(16)) u_dut1 (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty1), .fifo_dout(fifo_dout1),
    .fifo_rd_en(fifo_rd_en1), .m_data(m_data1), .m_valid(m_valid1),
    .m_ready(m_ready1), .xfer_count(xfer1), .buf_level(level1)
  );

  fifo_stream_reader #(.DATA_WIDTH(8), .BUF_DEPTH(2), .CNT_WIDTH(4)) u_dut2 (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty2), .fifo_dout(fifo_dout2),
    .fifo_rd_en(fifo_rd_en2), .m_data(m_data2), .m_valid(m_valid2),
    .m_ready(m_ready2), .xfer_count(xfer2), .buf_level(level2)
  );

  // Behavioural FIFOs: data appears on dout the edge after an accepted rd_en.
  logic [7:0] f1_mem [0:2047];
  int f1_wp = 0, f1_rp = 0;
  logic [7:0] f2_mem [0:63];
  int f2_wp = 0, f2_rp = 0;

  assign fifo_empty1 = (f1_wp == f1_rp);
  assign fifo_empty2 = (f2_wp == f2_rp);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      f1_rp <= f1_wp;
      f2_rp <= f2_wp;
    end else begin
      if (fifo_rd_en1) begin
        fifo_dout1 <= f1_mem[f1_rp[10:0]];
        f1_rp      <= f1_rp + 1;
      end
      if (fifo_rd_en2) begin
        fifo_dout2 <= f2_mem[f2_rp[5:0]];
        f2_rp      <= f2_rp + 1;
      end
    end
  end

  // Driver tasks
  task automatic push1(input logic [7:0] d, input bit track);
    f1_mem[f1_wp[10:0]] = d;
    f1_wp++;
    if (track) exp_q.push_back(d);
  endtask

  task automatic push2(input logic [7:0] d);
    f2_mem[f2_wp[5:0]] = d;
    f2_wp++;
    exp2_q.push_back(d);
  endtask

  task automatic test_reset();
    m_ready1 = 1'b0;
    m_ready2 = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    push1(8'hEE, 1'b0);
    #1;
    vectors++; if (fifo_rd_en1 !== 1'b0) begin miscompares++; $display("FAIL reset_rd_en: got %b want 0", fifo_rd_en1); end
    vectors++; if (m_valid1 !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", m_valid1); end
    vectors++; if (m_data1 !== 8'h00) begin miscompares++; $display("FAIL reset_data: got %h want 00", m_data1); end
    vectors++; if (xfer1 !== 16'd0) begin miscompares++; $display("FAIL reset_xfer: got %0d want 0", xfer1); end
    vectors++; if (level1 !== 4'd0) begin miscompares++; $display("FAIL reset_level: got %0d want 0", level1); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_word();
    logic [7:0] e;
    m_ready1 = 1'b1;
    @(negedge clk);
    push1(8'hA5, 1'b1);
    #1;
    vectors++; if (fifo_rd_en1 !== 1'b1) begin miscompares++; $display("FAIL single_rd_en: got %b want 1", fifo_rd_en1); end
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) begin
        vectors++; if (fifo_rd_en1 !== 1'b0) begin miscompares++; $display("FAIL single_rd_en_once: got %b want 0", fifo_rd_en1); end
      end
      vectors++; if (m_valid1 !== logic'(c == 2)) begin miscompares++; $display("FAIL single_valid c%0d: got %b want %b", c, m_valid1, c == 2); end
      if (m_valid1 && m_ready1) begin
        if (exp_q.size() == 0) begin vectors++; miscompares++; $display("FAIL single_extra: got %h want none", m_data1); end
        else begin
          e = exp_q.pop_front();
          vectors++; if (m_data1 !== e) begin miscompares++; $display("FAIL single_data: got %h want %h", m_data1, e); end
        end
      end
    end
    vectors++; if (xfer1 !== 16'd1) begin miscompares++; $display("FAIL single_xfer: got %0d want 1", xfer1); end
  endtask

  task automatic test_streaming();
    logic [7:0] e;
    int t;
    m_ready1 = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) push1(8'(i), 1'b1);
    t = 0;
    do begin @(negedge clk); t++; end while (m_valid1 !== 1'b1 && t < 10);
    vectors++; if (t != 2) begin miscompares++; $display("FAIL stream_latency: got %0d clk want 2", t); end
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk);
      vectors++;
      if (m_valid1 !== 1'b1) begin miscompares++; $display("FAIL stream_bubble word%0d: got valid %b want 1", k, m_valid1); end
      else begin
        e = exp_q.pop_front();
        if (m_data1 !== e) begin miscompares++; $display("FAIL stream_data word%0d: got %h want %h", k, m_data1, e); end
      end
    end
    @(negedge clk);
    vectors++; if (m_valid1 !== 1'b0) begin miscompares++; $display("FAIL stream_tail_valid: got %b want 0", m_valid1); end
    vectors++; if (xfer1 !== 16'd17) begin miscompares++; $display("FAIL stream_xfer: got %0d want 17", xfer1); end
  endtask

  task automatic test_backpressure();
    logic [7:0] e;
    int t;
    m_ready1 = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) push1(8'(8'h10 + i), 1'b1);
    repeat (6) @(negedge clk);
    vectors++; if (level1 !== 4'd3) begin miscompares++; $display("FAIL bp_level: got %0d want 3", level1); end
    vectors++; if (fifo_rd_en1 !== 1'b0) begin miscompares++; $display("FAIL bp_rd_en: got %b want 0", fifo_rd_en1); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      vectors++; if (m_valid1 !== 1'b1 || m_data1 !== 8'h10) begin miscompares++; $display("FAIL bp_hold c%0d: got %b/%h want 1/10", c, m_valid1, m_data1); end
    end
    m_ready1 = 1'b1;
    t = 0;
    while (exp_q.size() != 0 && t < 40) begin
      if (m_valid1) begin
        e = exp_q.pop_front();
        vectors++; if (m_data1 !== e) begin miscompares++; $display("FAIL bp_data: got %h want %h", m_data1, e); end
      end
      @(negedge clk);
      t++;
    end
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL bp_timeout: got %0d left want 0", exp_q.size()); end
    vectors++; if (m_valid1 !== 1'b0) begin miscompares++; $display("FAIL bp_duplicate: got valid %b want 0", m_valid1); end
    vectors++; if (xfer1 !== 16'd25) begin miscompares++; $display("FAIL bp_xfer: got %0d want 25", xfer1); end
  endtask

  task automatic test_random();
    logic [7:0] e;
    int got = 0;
    int cyc = 0;
    fork
      begin
        for (int i = 0; i < 1000; ) begin
          @(negedge clk);
          if ($urandom_range(0, 1) == 1) begin
            push1(8'($urandom_range(0, 255)), 1'b1);
            i++;
          end
        end
      end
      begin
        while (got < 1000 && cyc < 20000) begin
          @(negedge clk);
          cyc++;
          m_ready1 = 1'($urandom_range(0, 1));
          if (m_valid1 && m_ready1) begin
            e = exp_q.pop_front();
            vectors++; if (m_data1 !== e) begin miscompares++; $display("FAIL random_data word%0d: got %h want %h", got, m_data1, e); end
            got++;
          end
        end
      end
    join
    vectors++; if (got != 1000) begin miscompares++; $display("FAIL random_timeout: got %0d words want 1000", got); end
    m_ready1 = 1'b1;
    @(negedge clk);
    vectors++; if (xfer1 !== 16'd1025) begin miscompares++; $display("FAIL random_xfer: got %0d want 1025", xfer1); end
    vectors++; if (level1 !== 4'd0) begin miscompares++; $display("FAIL random_level: got %0d want 0", level1); end
  endtask

  task automatic test_reset_midstream();
    logic [7:0] e;
    m_ready1 = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) push1(8'(8'h51 + i), 1'b0);
    repeat (3) @(negedge clk);
    vectors++; if (level1 !== 4'd2 || fifo_rd_en1 !== 1'b0) begin miscompares++; $display("FAIL mid_setup: got level %0d rd_en %b want 2/0", level1, fifo_rd_en1); end
    rst = 1'b1;
    #1;
    vectors++; if (m_valid1 !== 1'b0) begin miscompares++; $display("FAIL mid_valid: got %b want 0", m_valid1); end
    vectors++; if (fifo_rd_en1 !== 1'b0) begin miscompares++; $display("FAIL mid_rd_en: got %b want 0", fifo_rd_en1); end
    vectors++; if (xfer1 !== 16'd0) begin miscompares++; $display("FAIL mid_xfer: got %0d want 0", xfer1); end
    @(negedge clk);
    rst = 1'b0;
    m_ready1 = 1'b1;
    @(negedge clk);
    push1(8'h3C, 1'b1);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (m_valid1) begin
        if (exp_q.size() == 0) begin vectors++; miscompares++; $display("FAIL mid_extra: got %h want none", m_data1); end
        else begin
          e = exp_q.pop_front();
          vectors++; if (m_data1 !== e) begin miscompares++; $display("FAIL mid_data: got %h want %h", m_data1, e); end
        end
      end
    end
    vectors++; if (exp_q.size() != 0) begin miscompares++; $display("FAIL mid_missing: got %0d left want 0", exp_q.size()); end
    vectors++; if (xfer1 !== 16'd1) begin miscompares++; $display("FAIL mid_xfer_after: got %0d want 1", xfer1); end
  endtask

  // Depth-2 issue rule stalls every third clk: word k emerges k + k/2 clks after the first.
  task automatic test_depth2_wrap();
    logic [7:0] e;
    int first = -1;
    int k = 0;
    int cyc = 0;
    m_ready2 = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 17; i++) push2(8'(8'h40 + i));
    while (k < 17 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (m_valid2) begin
        if (first < 0) first = cyc;
        e = exp2_q.pop_front();
        vectors++; if (m_data2 !== e) begin miscompares++; $display("FAIL d2_data word%0d: got %h want %h", k, m_data2, e); end
        vectors++; if (cyc - first != k + k / 2) begin miscompares++; $display("FAIL d2_cadence word%0d: got offset %0d want %0d", k, cyc - first, k + k / 2); end
        k++;
      end
    end
    vectors++; if (k != 17) begin miscompares++; $display("FAIL d2_timeout: got %0d words want 17", k); end
    vectors++; if (first != 2) begin miscompares++; $display("FAIL d2_latency: got %0d want 2", first); end
    @(negedge clk);
    vectors++; if (xfer2 !== 4'd1) begin miscompares++; $display("FAIL d2_wrap_xfer: got %0d want 1", xfer2); end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_streaming();
    test_backpressure();
    test_random();
    test_reset_midstream();
    test_depth2_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
